// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 key tracker.
//   state_t     decode FSM states (IDLE, PRESSED, BREAK)
//   BREAK_CODE  0xF0 release prefix
//   EXT_CODE    0xE0 extended-key prefix (ignored)
//   FRAME_BITS  bits per PS/2 frame (start + 8 data + parity + stop)
//   frame_ok    validity check of a complete frame
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        BREAK
    } state_t;

    localparam logic [7:0]  BREAK_CODE = 8'hF0;
    localparam logic [7:0]  EXT_CODE   = 8'hE0;
    localparam int unsigned FRAME_BITS = 11;

    // Frame layout: f[0]=start, f[8:1]=data LSB first, f[9]=parity, f[10]=stop.
    // Odd parity means data plus parity carries an odd number of ones.
    function automatic logic frame_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if: keyboard lines and decoded key outputs.
//   ps2_clk, ps2_data  raw PS/2 lines from the keyboard (idle high)
//   key_num            scan code of the key currently or last pressed
//   asc_num            ASCII of key_num, 0x00 if unmapped
//   key_times          press count modulo 256
//   key_valid          high while key_num is held
//   frame_err          one-cycle pulse per rejected frame
// Modports: master = the tracker, slave = the environment around it.
interface ps2_key_tracker_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_num;
    logic [7:0] asc_num;
    logic [7:0] key_times;
    logic       key_valid;
    logic       frame_err;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output key_num,
        output asc_num,
        output key_times,
        output key_valid,
        output frame_err
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  key_num,
        input  asc_num,
        input  key_times,
        input  key_valid,
        input  frame_err
    );

endinterface

// File: rtl/ps2_scan2ascii.sv
// ps2_scan2ascii: combinational scan code (set 2) to ASCII lookup.
//   scan   in  8  make code
//   ascii  out 8  lowercase letter, digit, space, CR, or 0x00 if unmapped
module ps2_scan2ascii (
    input  logic [7:0] scan,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = '0;
        case (scan)
            8'h1C: ascii = 8'h61; // a
            8'h32: ascii = 8'h62; // b
            8'h21: ascii = 8'h63; // c
            8'h23: ascii = 8'h64; // d
            8'h24: ascii = 8'h65; // e
            8'h2B: ascii = 8'h66; // f
            8'h34: ascii = 8'h67; // g
            8'h33: ascii = 8'h68; // h
            8'h43: ascii = 8'h69; // i
            8'h3B: ascii = 8'h6A; // j
            8'h42: ascii = 8'h6B; // k
            8'h4B: ascii = 8'h6C; // l
            8'h3A: ascii = 8'h6D; // m
            8'h31: ascii = 8'h6E; // n
            8'h44: ascii = 8'h6F; // o
            8'h4D: ascii = 8'h70; // p
            8'h15: ascii = 8'h71; // q
            8'h2D: ascii = 8'h72; // r
            8'h1B: ascii = 8'h73; // s
            8'h2C: ascii = 8'h74; // t
            8'h3C: ascii = 8'h75; // u
            8'h2A: ascii = 8'h76; // v
            8'h1D: ascii = 8'h77; // w
            8'h22: ascii = 8'h78; // x
            8'h35: ascii = 8'h79; // y
            8'h1A: ascii = 8'h7A; // z
            8'h45: ascii = 8'h30; // 0
            8'h16: ascii = 8'h31; // 1
            8'h1E: ascii = 8'h32; // 2
            8'h26: ascii = 8'h33; // 3
            8'h25: ascii = 8'h34; // 4
            8'h2E: ascii = 8'h35; // 5
            8'h36: ascii = 8'h36; // 6
            8'h3D: ascii = 8'h37; // 7
            8'h3E: ascii = 8'h38; // 8
            8'h46: ascii = 8'h39; // 9
            8'h29: ascii = 8'h20; // space
            8'h5A: ascii = 8'h0D; // enter
            default: ascii = '0;
        endcase
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: receives PS/2 keyboard frames and tracks the held key.
//   clk   in  system clock (single domain)
//   rst   in  asynchronous active-high reset
//   bus   ps2_key_tracker_if.master: ps2_clk/ps2_data in; key_num, asc_num,
//         key_times, key_valid, frame_err out
// Parameter TIMEOUT_CYC: clk cycles without a PS/2 falling edge after which
// a partial frame is abandoned silently.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic               clk,
    input  logic               rst,
    ps2_key_tracker_if.master  bus
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    // ------------------------------------------------------------------
    // Synchronizers: two flops per line, a third on ps2_clk for edge detect.
    // Reset to 1 so an idle-high line produces no spurious edge.
    // ------------------------------------------------------------------
    logic [1:0] clk_sync;
    logic       clk_d;
    logic [1:0] data_sync;
    logic       fall;
    logic       data_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            clk_d     <= 1'b1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk};
            clk_d     <= clk_sync[1];
            data_sync <= {data_sync[0], bus.ps2_data};
        end
    end

    assign fall   = clk_d & ~clk_sync[1];
    assign data_s = data_sync[1];

    // ------------------------------------------------------------------
    // Framer: shift in bits on each falling edge; bit_cnt tracks position.
    // The 11th bit is not stored; the frame is judged with it taken
    // directly from the synchronizer so the byte is usable this cycle.
    // ------------------------------------------------------------------
    logic [3:0]      bit_cnt;
    logic [9:0]      shift;
    logic [TO_W-1:0] to_cnt;
    logic [10:0]     frame_full;
    logic            last_bit;
    logic            rx_stb;
    logic [7:0]      rx_byte;
    logic            frame_err_r;

    assign frame_full = {data_s, shift};
    assign last_bit   = fall && (bit_cnt == 4'(FRAME_BITS - 1));
    assign rx_stb     = last_bit && frame_ok(frame_full);
    assign rx_byte    = frame_full[8:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            shift       <= '0;
            to_cnt      <= '0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= last_bit && !frame_ok(frame_full);
            if (fall) begin
                to_cnt <= '0;
                if (last_bit) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shift   <= {data_s, shift[9:1]};
                end
            end else if (bit_cnt != '0) begin
                if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // ASCII lookup of the incoming byte, registered alongside key_num.
    // ------------------------------------------------------------------
    logic [7:0] asc_lut;

    ps2_scan2ascii u_scan2ascii (
        .scan  (rx_byte),
        .ascii (asc_lut)
    );

    // ------------------------------------------------------------------
    // Decode FSM
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_nx;
    logic [7:0] key_num_r;
    logic [7:0] key_num_nx;
    logic [7:0] asc_num_r;
    logic [7:0] key_times_r;
    logic [7:0] key_times_nx;
    logic       key_valid_r;
    logic       key_valid_nx;
    logic       load_key;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            key_num_r   <= '0;
            asc_num_r   <= '0;
            key_times_r <= '0;
            key_valid_r <= 1'b0;
        end else begin
            state       <= state_nx;
            key_num_r   <= key_num_nx;
            key_times_r <= key_times_nx;
            key_valid_r <= key_valid_nx;
            if (load_key) begin
                asc_num_r <= asc_lut;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        key_num_nx   = key_num_r;
        key_times_nx = key_times_r;
        key_valid_nx = key_valid_r;
        load_key     = 1'b0;

        if (rx_stb && (rx_byte != EXT_CODE)) begin
            case (state)
                IDLE: begin
                    if (rx_byte == BREAK_CODE) begin
                        state_nx = BREAK;
                    end else begin
                        load_key     = 1'b1;
                        key_valid_nx = 1'b1;
                        state_nx     = PRESSED;
                    end
                end
                PRESSED: begin
                    // A repeat of the held key is typematic and leaves all
                    // outputs alone; any other make code is a rollover.
                    if (rx_byte == BREAK_CODE) begin
                        state_nx = BREAK;
                    end else if (rx_byte != key_num_r) begin
                        load_key = 1'b1;
                    end
                end
                BREAK: begin
                    if ((rx_byte == key_num_r) && key_valid_r) begin
                        key_valid_nx = 1'b0;
                        state_nx     = IDLE;
                    end else begin
                        state_nx = key_valid_r ? PRESSED : IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        if (load_key) begin
            key_num_nx   = rx_byte;
            key_times_nx = key_times_r + 8'd1;
        end
    end

    assign bus.key_num   = key_num_r;
    assign bus.asc_num   = asc_num_r;
    assign bus.key_times = key_times_r;
    assign bus.key_valid = key_valid_r;
    assign bus.frame_err = frame_err_r;

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 50000, clk cycles with no PS/2 falling edge before a partial frame is abandoned.
REQ-002 SHALL have ports (clock and reset first):
  clk        in   1  system clock; single clock domain.
  rst        in   1  reset, asynchronous, active-high.
  ps2_clk    in   1  raw PS/2 clock from the keyboard, asynchronous, idle high.
  ps2_data   in   1  raw PS/2 data from the keyboard, asynchronous, idle high.
  key_num    out  8  scan code of the key currently or last pressed.
  asc_num    out  8  ASCII code of key_num, 0x00 if unmapped.
  key_times  out  8  count of distinct key presses, modulo 256.
  key_valid  out  1  high while key_num is held down.
  frame_err  out  1  one-cycle pulse per rejected frame.

Function
REQ-003 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers, then detect a falling edge of synced ps2_clk with a third stage.
REQ-004 SHALL sample synced ps2_data on each detected falling edge into an 11-bit frame: start(0), 8 data bits LSB first, odd parity, stop(1); a bit counter 0..10 SHALL track position.
REQ-005 On the 11th bit, a frame with start=0, stop=1 and odd parity over data+parity SHALL yield a received byte; otherwise SHALL discard it and pulse frame_err for exactly one cycle.
REQ-006 If the bit counter is non-zero and TIMEOUT_CYC cycles pass with no falling edge, SHALL reset the counter to 0 without pulsing frame_err.
REQ-007 Byte 0xE0 SHALL be discarded with no state or output change.
REQ-008 Decode FSM states SHALL be IDLE, PRESSED and BREAK.
REQ-009 IDLE: byte 0xF0 -> BREAK; any other byte b -> key_num=b, key_times+1, key_valid=1, PRESSED.
REQ-010 PRESSED: b==key_num (typematic repeat) -> no change; 0xF0 -> BREAK; other b -> key_num=b, key_times+1, stay PRESSED (rollover).
REQ-011 BREAK: b==key_num with key_valid=1 -> key_valid=0, IDLE; any other byte -> no output change, go to PRESSED if key_valid else IDLE.
REQ-012 key_times SHALL wrap from 0xFF to 0x00.
REQ-013 key_num, asc_num, key_times and key_valid SHALL update together on the clk edge after the stop-bit falling edge is detected; asc_num SHALL be registered from a lookup of the received byte.
REQ-014 ASCII map: scan codes for A..Z -> 0x61..0x7A (lowercase), 0..9 -> 0x30..0x39, space 0x29 -> 0x20, Enter 0x5A -> 0x0D; all others -> 0x00.
REQ-015 key_num and asc_num SHALL hold their last values after release; only key_valid drops.

Reset
REQ-016 While rst=1: key_num, asc_num, key_times = 0x00; key_valid and frame_err = 0; FSM = IDLE; bit counter and timeout counter = 0; synchronizer flops = 1.
REQ-017 A reset mid-frame SHALL discard the partial frame; the first frame after reset SHALL be fully accepted if it begins with a fresh start bit.

Structure
REQ-018 Package ps2_pkg SHALL hold the FSM state type, the constants BREAK_CODE=0xF0, EXT_CODE=0xE0 and FRAME_BITS=11.
REQ-019 The scan-code-to-ASCII table SHALL be a combinational sub-module ps2_scan2ascii (8-bit in, 8-bit out).

Verification
REQ-020 Frame 0x1C with correct parity -> key_num=0x1C, asc_num=0x61, key_times=0x01, key_valid=1; then F0,1C -> key_valid=0, key_num stays 0x1C.
REQ-021 Typematic: 0x16 sent 5 times -> key_times=0x01, asc_num=0x31; then 0x1E (rollover) -> key_num=0x1E, key_times=0x02.
REQ-022 Frame with bad parity (or stop=0) -> frame_err pulses exactly one cycle, all other outputs unchanged.
REQ-023 Six bits of a frame, then idle for TIMEOUT_CYC+10 cycles, then valid 0x29 -> key_num=0x29, asc_num=0x20, no frame_err.
REQ-024 256 press/release pairs of 0x1C from reset -> key_times=0x00 after the 256th press; E0 prefix before a press causes no extra count.
REQ-025 rst asserted between bits 4 and 5 of a frame -> all outputs 0 immediately; the next full frame 0x5A -> key_num=0x5A, asc_num=0x0D.
